// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Produces a pixel-rate
//             enable, h/v counters, pixel request coordinates, polarity-
//             selectable syncs and a display-enable window. Sync, enable and
//             colour are delayed so that they line up with a colour source of
//             known latency. Colour is forced to zero while blanked.
//  Timing   : the pixel presented on x/y/req in tick window n must have its
//             colour on rgb_in during tick window n+LATENCY. de, hsync, vsync
//             and rgb_out for that pixel appear in tick window n+LATENCY+1.
//  Options  : define TEST_PATTERN_EN to add the pattern_sel input, which
//             replaces rgb_in with eight internally generated colour bars.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int PIXEL_DIV = 2,
  parameter int COLOR_W   = 1,
  parameter int LATENCY   = 1,
  parameter int CW        = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 pix_ce,
  output logic [CW-1:0]        x,
  output logic [CW-1:0]        y,
  output logic                 req,
  input  logic [3*COLOR_W-1:0] rgb_in,
`ifdef TEST_PATTERN_EN
  input  logic                 pattern_sel,
`endif
  output logic [3*COLOR_W-1:0] rgb_out,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_DISPLAY + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int DIV_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  localparam logic H_ACT = (H_POL != 0);
  localparam logic V_ACT = (V_POL != 0);

  // Pipe word: {pattern bars (optional), vsync_raw, hsync_raw, req}
`ifdef TEST_PATTERN_EN
  localparam int PW = 6;
`else
  localparam int PW = 3;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    h_q, h_d;
  logic [CW-1:0]    v_q, v_d;
  logic             tick;

  logic             h_active, v_active, hs_raw, vs_raw;

  logic             pix_ce_q, req_q, hs_raw_q, vs_raw_q;
  logic             line_start_q, frame_start_q;
  logic [CW-1:0]    x_q, y_q;

  logic [PW-1:0]    stage_in;
  logic [PW-1:0]    tap;

  logic             de_q, hsync_q, vsync_q;
  logic [3*COLOR_W-1:0] rgb_out_q;
  logic [3*COLOR_W-1:0] colour_src;

  // Pixel tick: last cycle of each divider period
  assign tick = (div_q == DIV_LAST);

  // Next-state for divider and raster counters; counters move only on a tick
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Region decode straight from the counters; no extra region state is kept
  always_comb begin
    h_active = (h_q < CW'(H_DISPLAY));
    v_active = (v_q < CW'(V_DISPLAY));
    hs_raw   = (h_q >= CW'(H_SYNC_START)) && (h_q < CW'(H_SYNC_END));
    vs_raw   = (v_q >= CW'(V_SYNC_START)) && (v_q < CW'(V_SYNC_END));
  end

  // Divider and raster counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Undelayed stage: request, coordinates, raw syncs and start pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_ce_q      <= 1'b0;
      req_q         <= 1'b0;
      hs_raw_q      <= 1'b0;
      vs_raw_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_ce_q      <= tick;
      line_start_q  <= tick && (h_q == '0);
      frame_start_q <= tick && (h_q == '0) && (v_q == '0);
      if (tick) begin
        req_q    <= h_active && v_active;
        hs_raw_q <= hs_raw;
        vs_raw_q <= vs_raw;
        if (h_active && v_active) begin
          x_q <= h_q;
          y_q <= v_q;
        end
      end
    end
  end

`ifdef TEST_PATTERN_EN
  logic [2:0] bar_q;

  // Colour-bar index for the pixel being requested, aligned with req
  always_ff @(posedge clk) begin
    if (rst) begin
      bar_q <= 3'd0;
    end else if (tick) begin
      bar_q <= 3'(({3'b000, h_q} * (CW+3)'(8)) / (CW+3)'(H_DISPLAY));
    end
  end

  assign stage_in = {bar_q, vs_raw_q, hs_raw_q, req_q};
`else
  assign stage_in = {vs_raw_q, hs_raw_q, req_q};
`endif

  generate
    if (LATENCY == 0) begin : g_bypass
      assign tap = stage_in;
    end else begin : g_pipe
      logic [PW-1:0] pipe_q [LATENCY];

      // Delay line matching the colour source latency; cleared stages are blank
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else if (tick) begin
          pipe_q[0] <= stage_in;
          for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign tap = pipe_q[LATENCY-1];
    end
  endgenerate

  // Colour source selection ahead of the blanking gate
  always_comb begin
    colour_src = rgb_in;
`ifdef TEST_PATTERN_EN
    if (pattern_sel) begin
      colour_src = {{COLOR_W{tap[5]}}, {COLOR_W{tap[4]}}, {COLOR_W{tap[3]}}};
    end
`endif
  end

  // Output stage: enable, polarity-mapped syncs and blank-gated colour
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q      <= 1'b0;
      hsync_q   <= ~H_ACT;
      vsync_q   <= ~V_ACT;
      rgb_out_q <= '0;
    end else if (tick) begin
      de_q      <= tap[0];
      hsync_q   <= tap[1] ? H_ACT : ~H_ACT;
      vsync_q   <= tap[2] ? V_ACT : ~V_ACT;
      rgb_out_q <= tap[0] ? colour_src : '0;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign x           = x_q;
  assign y           = y_q;
  assign req         = req_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_out_q;

endmodule
`default_nettype wire
